// File: rtl/pll_reset_seq.sv
// ============================================================================
// pll_reset_seq : CC_PLL start-up / recovery sequencer on the reference clock.
//   Optional lock-loss counter compiled in with PLL_SEQ_LOSS_CNT_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module pll_reset_seq #(
    parameter int unsigned LOCK_TIMEOUT    = 1000000,
    parameter int unsigned SETTLE_CYCLES   = 10000,
    parameter int unsigned STDY_RST_CYCLES = 4,
    parameter int unsigned MAX_RETRIES     = 3,
    parameter int unsigned CNT_W           = 24,
    parameter int unsigned BLINK_BIT       = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       pll_lock_stdy,
    output logic       stdy_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [7:0] lost_cnt,
    output logic       led
);

    localparam int unsigned RTY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [2:0] S_HOLD   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_FAULT  = 3'd4;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(STDY_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX     = RTY_W'(MAX_RETRIES);

    logic             lock_meta, lock_s;
    logic             stdy_meta, stdy_s;
    logic [2:0]       state, state_nx;
    logic [CNT_W-1:0] timer, timer_nx;
    logic [RTY_W-1:0] retries, retries_nx, retries_inc;
    logic [BLINK_BIT:0] blink;

    // Both PLL status lines are asynchronous to clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            stdy_meta <= 1'b0;
            stdy_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
            stdy_meta <= pll_lock_stdy;
            stdy_s    <= stdy_meta;
        end
    end

    assign retries_inc = retries + 1'b1;

    always_comb begin
        state_nx   = state;
        timer_nx   = timer + 1'b1;
        retries_nx = retries;
        case (state)
            S_HOLD: begin
                if (timer == HOLD_LAST) begin
                    state_nx = S_WAIT;
                    timer_nx = '0;
                end
            end
            S_WAIT: begin
                // Lock takes priority over a coincident timeout.
                if (lock_s) begin
                    state_nx = S_SETTLE;
                    timer_nx = '0;
                end else if (timer == TO_LAST) begin
                    retries_nx = retries_inc;
                    timer_nx   = '0;
                    state_nx   = (retries_inc == RTY_MAX) ? S_FAULT : S_HOLD;
                end
            end
            S_SETTLE: begin
                if (!lock_s) begin
                    state_nx = S_WAIT;
                    timer_nx = '0;
                end else if (timer == SETTLE_LAST) begin
                    timer_nx = timer;
                    if (stdy_s) begin
                        state_nx   = S_RUN;
                        timer_nx   = '0;
                        retries_nx = '0;
                    end
                end
            end
            S_RUN: begin
                timer_nx = '0;
                if (!stdy_s || !lock_s) begin
                    state_nx = S_HOLD;
                end
            end
            S_FAULT: begin
                timer_nx = '0;
            end
            default: begin
                state_nx = S_HOLD;
                timer_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_HOLD;
            timer   <= '0;
            retries <= '0;
            blink   <= '0;
        end else begin
            state   <= state_nx;
            timer   <= timer_nx;
            retries <= retries_nx;
            blink   <= blink + 1'b1;
        end
    end

    // Outputs are decoded from the current state and registered, so they lag it by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stdy_rst  <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fault     <= 1'b0;
            led       <= 1'b0;
        end else begin
            stdy_rst  <= (state == S_HOLD);
            sys_rst_n <= (state == S_RUN);
            ready     <= (state == S_RUN);
            fault     <= (state == S_FAULT);
            led       <= (state == S_RUN) | ((state == S_FAULT) & blink[BLINK_BIT]);
        end
    end

`ifdef PLL_SEQ_LOSS_CNT_EN
    logic       lost_inc;
    logic [7:0] lost_q;

    assign lost_inc = (state == S_RUN) && (state_nx == S_HOLD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lost_q <= 8'd0;
        end else if (lost_inc && (lost_q != 8'hFF)) begin
            lost_q <= lost_q + 8'd1;
        end
    end

    assign lost_cnt = lost_q;
`else
    assign lost_cnt = 8'd0;
`endif

endmodule

`default_nettype wire
